master_rx_deser: RTL and testbench

//  Master-side read-data receiver, directly downstream of the slave->master mux.

---
 rtl/master_rx_deser_pkg.sv | 20 ++
 rtl/master_rx_deser_timeout_ctr.sv | 26 ++
 rtl/master_rx_deser.sv | 119 +++++++++++
 tb/tb_master_rx_deser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/master_rx_deser_pkg.sv
// Shared bus definitions for the master-side receive path:
// receiver states, grant encodings and the default word width.
package master_rx_deser_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_WAIT  = 2'd1,
        RX_SHIFT = 2'd2
    } rx_state_e;

    localparam logic [1:0] GRANT_M1 = 2'b01;
    localparam logic [1:0] GRANT_M2 = 2'b10;

    localparam logic [2:0] SGRANT_S1 = 3'b011;
    localparam logic [2:0] SGRANT_S2 = 3'b101;
    localparam logic [2:0] SGRANT_S3 = 3'b111;

    localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/master_rx_deser_timeout_ctr.sv
// Wait-cycle counter: counts enabled cycles and flags the cycle in which
// the TIMEOUT-th consecutive enabled cycle occurs. Shared with the tx path.
module bus_timeout_ctr #(
    parameter int TIMEOUT = 255,
    parameter int TMO_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tmo_cnt <= '0;
        end else if (enable) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign expired = enable && (tmo_cnt == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/master_rx_deser.sv
// Master read-data receiver: waits for the muxed slave return path and
// deserialises one LSB-first word, flagging timeout or mid-word abort.
module master_rx_deser
    import master_rx_deser_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 255,
    parameter int TMO_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_start,
    input  logic                  slave_valid,
    input  logic                  slave_ready,
    input  logic                  tx_data,
    output logic                  rx_busy,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_done,
    output logic                  rx_err
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    rx_state_e             state, nxt_state;
    logic [DATA_WIDTH-1:0] shreg, nxt_shreg;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [CW-1:0]         bit_cnt, nxt_cnt;
    logic                  nxt_done, nxt_err;
    logic                  tmo_clear, tmo_en, tmo_expired;

    // Counter only runs while nobody answers; any sign of life restarts it.
    assign tmo_en    = (state == RX_WAIT) && !slave_valid && !slave_ready;
    assign tmo_clear = (state != RX_WAIT) || slave_valid || slave_ready;

    bus_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_tmo (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RX_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            rx_data <= '0;
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            rx_busy <= 1'b0;
        end else begin
            state   <= nxt_state;
            shreg   <= nxt_shreg;
            bit_cnt <= nxt_cnt;
            rx_data <= nxt_data;
            rx_done <= nxt_done;
            rx_err  <= nxt_err;
            rx_busy <= (nxt_state != RX_IDLE);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_shreg = shreg;
        nxt_cnt   = bit_cnt;
        nxt_data  = rx_data;
        nxt_done  = 1'b0;
        nxt_err   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (rx_start) begin
                    nxt_state = RX_WAIT;
                    nxt_shreg = '0;
                    nxt_cnt   = '0;
                end
            end
            RX_WAIT: begin
                if (slave_valid) begin
                    nxt_shreg    = '0;
                    nxt_shreg[0] = tx_data;
                    if (DATA_WIDTH == 1) begin
                        nxt_data  = nxt_shreg;
                        nxt_done  = 1'b1;
                        nxt_state = RX_IDLE;
                    end else begin
                        nxt_cnt   = CW'(1);
                        nxt_state = RX_SHIFT;
                    end
                end else if (tmo_expired) begin
                    nxt_err   = 1'b1;
                    nxt_state = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (slave_valid) begin
                    for (int i = 0; i < DATA_WIDTH; i++) begin
                        if (bit_cnt == CW'(i)) nxt_shreg[i] = tx_data;
                    end
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        nxt_data  = nxt_shreg;
                        nxt_done  = 1'b1;
                        nxt_state = RX_IDLE;
                    end else begin
                        nxt_cnt = bit_cnt + CW'(1);
                    end
                end else begin
                    nxt_err   = 1'b1;
                    nxt_state = RX_IDLE;
                end
            end
            default: nxt_state = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_master_rx_deser.sv
// Directed bench for master_rx_deser with a word-level reference model
// compared against the DUT on every falling edge.
module tb_master_rx_deser;

    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_start = 1'b0;
    logic          slave_valid = 1'b0;
    logic          slave_ready = 1'b0;
    logic          tx_data = 1'b0;
    logic          rx_busy;
    logic [DW-1:0] rx_data;
    logic          rx_done;
    logic          rx_err;

    int errors = 0;
    int checks = 0;

    master_rx_deser #(
        .DATA_WIDTH (DW),
        .TIMEOUT    (TMO),
        .TMO_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_start    (rx_start),
        .slave_valid (slave_valid),
        .slave_ready (slave_ready),
        .tx_data     (tx_data),
        .rx_busy     (rx_busy),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err      (rx_err)
    );

    always #5 clk = ~clk;

    // Reference model: a receive is "got" bits collected plus a count of
    // consecutive silent wait cycles.
    bit          m_busy = 0;
    int          m_got = 0;
    int          m_wait = 0;
    logic [DW-1:0] m_word = '0;
    logic [DW-1:0] m_data = '0;
    bit          m_done = 0;
    bit          m_err = 0;

    always @(posedge clk) begin
        m_done = 0;
        m_err  = 0;
        if (rst) begin
            m_busy = 0;
            m_data = '0;
        end else if (!m_busy) begin
            if (rx_start) begin
                m_busy = 1;
                m_got  = 0;
                m_wait = 0;
                m_word = '0;
            end
        end else if (slave_valid) begin
            m_word = m_word | (DW'(tx_data) << m_got);
            m_got++;
            if (m_got == DW) begin
                m_data = m_word;
                m_done = 1;
                m_busy = 0;
            end
        end else if (m_got > 0) begin
            m_err  = 1;
            m_busy = 0;
        end else if (slave_ready) begin
            m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait == TMO) begin
                m_err  = 1;
                m_busy = 0;
            end
        end
    end

    bit cmp_en = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (rx_busy !== m_busy || rx_data !== m_data ||
                rx_done !== m_done || rx_err !== m_err) begin
                errors++;
                $display("FAIL model t=%0t busy=%b/%b data=%h/%h done=%b/%b err=%b/%b",
                         $time, rx_busy, m_busy, rx_data, m_data,
                         rx_done, m_done, rx_err, m_err);
            end
            if (rx_done && rx_err) begin
                errors++;
                $display("FAIL done_err_overlap t=%0t", $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic v, input logic r,
                       input logic d);
        rx_start    = st;
        slave_valid = v;
        slave_ready = r;
        tx_data     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n,
                             input bit noise);
        logic [DW-1:0] t;
        t = w;
        for (int i = 0; i < n; i++) begin
            cyc(noise && (i == 2 || i == 5), 1'b1, 1'b0, t[0]);
            t = t >> 1;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", 32'(rx_busy), 32'd0);
        chk("reset_data", 32'(rx_data), 32'h00);
        chk("reset_pulses", {30'd0, rx_done, rx_err}, 32'd0);
        rst = 1'b0;
        cmp_en = 1;

        // 1: ready-only wait then 0xA5
        cyc(1, 0, 0, 0);
        chk("t1_busy", 32'(rx_busy), 32'd1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        send_bits(8'hA5, 8, 0);
        chk("t1_done", 32'(rx_done), 32'd1);
        chk("t1_data", 32'(rx_data), 32'hA5);
        chk("t1_busy_low", 32'(rx_busy), 32'd0);
        cyc(0, 0, 0, 0);
        chk("t1_done_pulse", 32'(rx_done), 32'd0);

        // 2: timeout after 16 silent cycles
        cyc(1, 0, 0, 0);
        repeat (15) cyc(0, 0, 0, 0);
        chk("t2_no_err_early", 32'(rx_err), 32'd0);
        cyc(0, 0, 0, 0);
        chk("t2_err", 32'(rx_err), 32'd1);
        chk("t2_data_kept", 32'(rx_data), 32'hA5);
        chk("t2_busy", 32'(rx_busy), 32'd0);
        cyc(0, 0, 0, 0);

        // 3: abort after 3 bits, then 0x3C
        cyc(1, 0, 0, 0);
        send_bits(8'hFF, 3, 0);
        cyc(0, 0, 1, 0);
        chk("t3_err", 32'(rx_err), 32'd1);
        chk("t3_data_kept", 32'(rx_data), 32'hA5);
        cyc(1, 0, 0, 0);
        send_bits(8'h3C, 8, 0);
        chk("t3_data", 32'(rx_data), 32'h3C);
        cyc(0, 0, 0, 0);

        // 4: reset after 5 bits, then 0xFF
        cyc(1, 0, 0, 0);
        send_bits(8'h55, 5, 0);
        rst = 1'b1;
        cyc(0, 1, 0, 1);
        rst = 1'b0;
        chk("t4_rst_out", {23'd0, rx_busy, rx_data}, 32'd0);
        chk("t4_rst_pulses", {30'd0, rx_done, rx_err}, 32'd0);
        cyc(1, 0, 0, 0);
        send_bits(8'hFF, 8, 0);
        chk("t4_data", 32'(rx_data), 32'hFF);

        // 5: rx_start noise mid-word, then back-to-back via start on done
        cyc(1, 0, 0, 0);
        send_bits(8'h81, 8, 1);
        chk("t5_data81", 32'(rx_data), 32'h81);
        chk("t5_done81", 32'(rx_done), 32'd1);
        cyc(1, 0, 0, 0);
        chk("t5_b2b_busy", 32'(rx_busy), 32'd1);
        send_bits(8'h7E, 8, 0);
        chk("t5_data7e", 32'(rx_data), 32'h7E);

        // 6: idle activity without rx_start
        for (int i = 0; i < 6; i++) cyc(0, 1'(i), 1'(i >> 1), 1'(~i));
        chk("t6_busy", 32'(rx_busy), 32'd0);
        chk("t6_data", 32'(rx_data), 32'h7E);

        cyc(0, 0, 0, 0);
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
